// File: rtl/input_debounce_bank.sv
// rtl/input_debounce_bank.sv - synchronised, debounced input bank with sticky events and interrupt
module input_debounce_bank #(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit RESET_LEVEL     = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] din,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic [CHANNELS-1:0] evt_status,
  input  logic [CHANNELS-1:0] evt_clear,
  input  logic [CHANNELS-1:0] irq_en,
  output logic                irq
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CHANNELS-1:0] LEVEL_INIT = {CHANNELS{RESET_LEVEL}};

  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] sync_d [SYNC_STAGES];
  logic [CW-1:0]       cnt_q  [CHANNELS];
  logic [CW-1:0]       cnt_d  [CHANNELS];
  logic [CHANNELS-1:0] level_q, level_d;
  logic [CHANNELS-1:0] rise_q, rise_d;
  logic [CHANNELS-1:0] fall_q, fall_d;
  logic [CHANNELS-1:0] evt_status_q, evt_status_d;
  logic                irq_q, irq_d;
  logic [CHANNELS-1:0] s;

  assign s = sync_q[SYNC_STAGES-1];

  // Synchroniser chain: stage 0 samples the raw pins, later stages shift along.
  always_comb begin
    sync_d[0] = din;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  // Debounce: a mismatch must persist DEBOUNCE_CYCLES edges; any agreement restarts the count.
  always_comb begin
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = '0;
      if (s[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          level_d[i] = s[i];
          rise_d[i]  = s[i];
          fall_d[i]  = ~s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Sticky events (a new edge beats a same-cycle clear) and interrupt from the registered status.
  always_comb begin
    evt_status_d = (evt_status_q & ~evt_clear) | rise_d | fall_d;
    irq_d        = |(evt_status_q & irq_en);
  end

  // State registers; asynchronous reset discards any pending count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= LEVEL_INIT;
      end
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= '0;
      end
      level_q      <= LEVEL_INIT;
      rise_q       <= '0;
      fall_q       <= '0;
      evt_status_q <= '0;
      irq_q        <= 1'b0;
    end else begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_d[k];
      end
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      level_q      <= level_d;
      rise_q       <= rise_d;
      fall_q       <= fall_d;
      evt_status_q <= evt_status_d;
      irq_q        <= irq_d;
    end
  end

  assign level      = level_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign evt_status = evt_status_q;
  assign irq        = irq_q;

endmodule
